// File: rtl/istream_buffer.sv
// First-word-fall-through stream buffer: circular storage with registered
// occupancy count, flush, and synchronous reset of pointers/count only.
module istream_buffer #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 8
) (
  input  logic                     istream_clk,
  input  logic                     istream_rst,
  input  logic                     istream_valid,
  input  logic [DATA_WIDTH-1:0]    istream_data,
  output logic                     istream_ready,
  output logic                     istream_buff_full,
  output logic                     istream_buff_empty,
  input  logic                     istream_flush,
  output logic                     ostream_valid,
  output logic [DATA_WIDTH-1:0]    ostream_data,
  input  logic                     ostream_ready,
  output logic [$clog2(DEPTH):0]   buff_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]         wr_ptr;
  logic [AW-1:0]         rd_ptr;
  logic [CW-1:0]         count;
  logic                  push;
  logic                  pop;

  // Flags decode only from the registered count, so ready never depends on ostream_ready.
  assign istream_buff_full  = (count == CW'(DEPTH));
  assign istream_buff_empty = (count == '0);
  assign istream_ready      = ~istream_buff_full;
  assign ostream_valid      = ~istream_buff_empty;
  assign ostream_data       = istream_buff_empty ? '0 : mem[rd_ptr];
  assign buff_count         = count;

  assign push = istream_valid & istream_ready;
  assign pop  = ostream_valid & ostream_ready;

  always_ff @(posedge istream_clk) begin
    if (istream_rst || istream_flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage is deliberately not reset; the empty gate hides stale contents.
  always_ff @(posedge istream_clk) begin
    if (push && !istream_rst && !istream_flush)
      mem[wr_ptr] <= istream_data;
  end

endmodule

// File: tb/tb_istream_buffer.sv
// Self-checking bench for istream_buffer: a vector table plus hand-written
// sequences for fill/overflow, full push+pop, and steady-state wrap.
module tb_istream_buffer;

  localparam int DW = 32;
  localparam int DP = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          ivalid = 1'b0;
  logic [DW-1:0] idata = '0;
  logic          iready;
  logic          full;
  logic          empty;
  logic          flush = 1'b0;
  logic          ovalid;
  logic [DW-1:0] odata;
  logic          oready = 1'b0;
  logic [3:0]    count;

  int pass_cnt  = 0;
  int total_cnt = 0;

  istream_buffer #(.DATA_WIDTH(DW), .DEPTH(DP)) dut (
    .istream_clk        (clk),
    .istream_rst        (rst),
    .istream_valid      (ivalid),
    .istream_data       (idata),
    .istream_ready      (iready),
    .istream_buff_full  (full),
    .istream_buff_empty (empty),
    .istream_flush      (flush),
    .ostream_valid      (ovalid),
    .ostream_data       (odata),
    .ostream_ready      (oready),
    .buff_count         (count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          rst;
    logic          flush;
    logic          ivalid;
    logic [DW-1:0] idata;
    logic          oready;
    int            exp_count;
    logic [DW-1:0] exp_odata;
  } vec_t;

  vec_t vecs [20];

  function automatic vec_t mk(logic r, logic f, logic v, logic [DW-1:0] d,
                              logic o, int c, logic [DW-1:0] od);
    vec_t t;
    t.rst = r; t.flush = f; t.ivalid = v; t.idata = d; t.oready = o;
    t.exp_count = c; t.exp_odata = od;
    return t;
  endfunction

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s actual=0x%0h expected=0x%0h at %0t", name, act, exp, $time);
  endtask

  // Flags checked against a count the bench itself expects.
  task automatic check_state(input string tag, input int c, input logic [DW-1:0] od);
    check({tag, " count"},  DW'(count),  DW'(c));
    check({tag, " ovalid"}, DW'(ovalid), DW'(c != 0));
    check({tag, " odata"},  odata,       (c != 0) ? od : '0);
    check({tag, " iready"}, DW'(iready), DW'(c != DP));
    check({tag, " full"},   DW'(full),   DW'(c == DP));
    check({tag, " empty"},  DW'(empty),  DW'(c == 0));
  endtask

  task automatic step(input logic r, input logic f, input logic v,
                      input logic [DW-1:0] d, input logic o);
    rst = r; flush = f; ivalid = v; idata = d; oready = o;
    @(posedge clk);
    #1;
  endtask

  initial begin
    vecs[0]  = mk(1, 0, 1, 32'h0000_0077, 1, 0, 0);
    vecs[1]  = mk(0, 0, 1, 32'hA5A5_A5A5, 0, 1, 32'hA5A5_A5A5);
    vecs[2]  = mk(0, 0, 1, 32'h1,         1, 1, 32'h1);
    vecs[3]  = mk(0, 0, 0, 32'hDEAD,      1, 0, 0);
    vecs[4]  = mk(0, 0, 0, 32'hBEEF,      1, 0, 0);
    vecs[5]  = mk(0, 0, 1, 32'h2,         1, 1, 32'h2);
    vecs[6]  = mk(0, 0, 1, 32'h3,         0, 2, 32'h2);
    vecs[7]  = mk(0, 0, 1, 32'h4,         0, 3, 32'h2);
    vecs[8]  = mk(0, 0, 1, 32'h5,         0, 4, 32'h2);
    vecs[9]  = mk(0, 0, 1, 32'h6,         0, 5, 32'h2);
    vecs[10] = mk(0, 1, 1, 32'h7,         1, 0, 0);
    vecs[11] = mk(0, 0, 1, 32'h10,        0, 1, 32'h10);
    vecs[12] = mk(0, 0, 1, 32'h11,        0, 2, 32'h10);
    vecs[13] = mk(0, 0, 1, 32'h12,        0, 3, 32'h10);
    vecs[14] = mk(0, 0, 1, 32'h13,        0, 4, 32'h10);
    vecs[15] = mk(0, 0, 1, 32'h14,        0, 5, 32'h10);
    vecs[16] = mk(0, 0, 1, 32'h15,        0, 6, 32'h10);
    vecs[17] = mk(1, 0, 1, 32'h99,        1, 0, 0);
    vecs[18] = mk(0, 0, 1, 32'h55,        0, 1, 32'h55);
    vecs[19] = mk(0, 0, 0, 32'h0,         1, 0, 0);

    #2;
    for (int i = 0; i < 20; i++) begin
      step(vecs[i].rst, vecs[i].flush, vecs[i].ivalid, vecs[i].idata, vecs[i].oready);
      check_state($sformatf("vec%0d", i), vecs[i].exp_count, vecs[i].exp_odata);
    end

    // Fill to full, hold off the 9th word, then pop-only when full.
    step(1, 0, 0, 0, 0);
    for (int i = 1; i <= DP; i++) begin
      step(0, 0, 1, DW'(i), 0);
      check_state($sformatf("fill%0d", i), i, 32'h1);
    end
    for (int i = 0; i < 2; i++) begin
      step(0, 0, 1, 32'h9, 0);
      check_state("overflow_hold", DP, 32'h1);
    end
    step(0, 0, 1, 32'h9, 1);
    check_state("full_push_pop", DP - 1, 32'h2);
    for (int i = 2; i <= DP; i++) begin
      check($sformatf("drain%0d data", i), odata, DW'(i));
      step(0, 0, 0, 0, 1);
    end
    check_state("drained", 0, 0);

    // Steady state at count 4 with concurrent push and pop across pointer wrap.
    step(1, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) step(0, 0, 1, 32'h100 + DW'(i), 0);
    check_state("pre_stream", 4, 32'h100);
    for (int i = 0; i < 20; i++) begin
      check($sformatf("stream%0d data", i), odata, 32'h100 + DW'(i));
      step(0, 0, 1, 32'h104 + DW'(i), 1);
      check($sformatf("stream%0d count", i), DW'(count), 32'd4);
    end
    for (int i = 0; i < 4; i++) begin
      check($sformatf("tail%0d data", i), odata, 32'h114 + DW'(i));
      step(0, 0, 0, 0, 1);
    end
    check_state("tail_empty", 0, 0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/istream_buffer.md
ISTREAM_BUFFER -- requirements
Module: istream_buffer

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 32, width of the input stream data bus and stored words.
REQ-002 The block SHALL have parameter DEPTH, default 8, number of buffer entries; power of two, minimum 2.
REQ-003 The block SHALL have port istream_clk  input  1  single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port istream_rst  input  1  reset, synchronous, active-high.
REQ-005 The block SHALL have port istream_valid  input  1  upstream data on istream_data is valid.
REQ-006 The block SHALL have port istream_data  input  DATA_WIDTH  upstream stream data word.
REQ-007 The block SHALL have port istream_ready  output  1  buffer can accept a word this cycle.
REQ-008 The block SHALL have port istream_buff_full  output  1  buffer holds DEPTH words.
REQ-009 The block SHALL have port istream_buff_empty  output  1  buffer holds zero words.
REQ-010 The block SHALL have port istream_flush  input  1  discard all stored words.
REQ-011 The block SHALL have port ostream_valid  output  1  ostream_data holds the oldest stored word.
REQ-012 The block SHALL have port ostream_data  output  DATA_WIDTH  oldest stored word, first-word-fall-through.
REQ-013 The block SHALL have port ostream_ready  input  1  downstream consumes ostream_data this cycle.
REQ-014 The block SHALL have port buff_count  output  $clog2(DEPTH)+1  number of stored words, 0..DEPTH.

Function
REQ-015 Push SHALL occur on a rising edge when istream_valid=1 and istream_ready=1; word written at wr_ptr, wr_ptr incremented.
REQ-016 Pop SHALL occur on a rising edge when ostream_valid=1 and ostream_ready=1; rd_ptr incremented.
REQ-017 wr_ptr and rd_ptr SHALL be $clog2(DEPTH) bits and wrap from DEPTH-1 to 0 with no other effect.
REQ-018 buff_count SHALL update next cycle as: +1 push only, -1 pop only, unchanged on push and pop together or on neither.
REQ-019 istream_ready SHALL equal NOT istream_buff_full, decoded from registered buff_count; no combinational path from ostream_ready.
REQ-020 istream_buff_full SHALL be 1 exactly when buff_count=DEPTH; istream_buff_empty SHALL be 1 exactly when buff_count=0.
REQ-021 ostream_valid SHALL equal NOT istream_buff_empty; ostream_data SHALL be mem[rd_ptr] when valid, all-zero when empty.
REQ-022 Latency SHALL be one cycle: a word pushed at edge N is visible on ostream_data/ostream_valid after edge N.
REQ-023 When full, push and pop requested together: only the pop SHALL occur (istream_ready=0); count becomes DEPTH-1.
REQ-024 When empty, push and pop requested together: only the push SHALL occur (ostream_valid=0); count becomes 1.
REQ-025 istream_valid while istream_ready=0 SHALL not alter state; upstream holds data, so no overflow error exists.
REQ-026 istream_data SHALL be ignored while istream_valid=0; ostream_ready SHALL be ignored while ostream_valid=0.
REQ-027 istream_flush=1 SHALL clear wr_ptr, rd_ptr, buff_count at the next edge; any push or pop that cycle SHALL be discarded.
REQ-028 ostream_data SHALL remain stable while ostream_valid=1 and ostream_ready=0.

Reset
REQ-029 istream_rst=1 at a rising edge SHALL clear wr_ptr, rd_ptr, buff_count to 0, with priority over push, pop, flush.
REQ-030 Reset values SHALL be: istream_ready=1, istream_buff_empty=1, istream_buff_full=0, ostream_valid=0, ostream_data=0, buff_count=0.
REQ-031 Storage array SHALL not be reset; contents SHALL be unobservable after reset because empty gates ostream_data.
REQ-032 Reset mid-operation SHALL drop all stored words; first push after reset SHALL appear as the next ostream_data word.

Verification (DATA_WIDTH=32, DEPTH=8)
REQ-033 Push 8 words 0x1..0x8, ostream_ready=0 -> full=1, ready=0, count=8; 9th valid word 0x9 not accepted; pops return 0x1..0x8 in order.
REQ-034 Empty buffer, push 0xA5A5A5A5 at edge N -> ostream_valid=1, ostream_data=0xA5A5A5A5 after edge N; count=1.
REQ-035 Count=4, continuous push and pop for 20 cycles -> count stays 4, data in order, pointers wrap with no loss or duplication.
REQ-036 Full buffer, istream_valid=1 and ostream_ready=1 same cycle -> pop only, count=7, ready=1 next cycle.
REQ-037 Count=5, istream_flush=1 with push requested -> count=0, empty=1, ostream_valid=0, ostream_data=0; pushed word discarded.
REQ-038 Count=6, istream_rst=1 for one cycle -> all outputs at reset values; next push 0x55 is the next ostream_data word.
